// File: rtl/sram_arbiter_if.sv
// Client-side handshake bundle for sram_arbiter: per-client request/direction/address/data
// flattened into packed buses, plus the shared read-return, grant and done outputs.
interface sram_arbiter_if #(
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CLIENTS = 2
);
  logic [NUM_CLIENTS-1:0]            clientRequest;
  logic [NUM_CLIENTS-1:0]            clientWrite;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] clientAddress;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0] clientWriteData;
  logic [DATA_WIDTH-1:0]             clientReadData;
  logic [NUM_CLIENTS-1:0]            clientGrant;
  logic [NUM_CLIENTS-1:0]            clientDone;

  modport master (
    output clientRequest, clientWrite, clientAddress, clientWriteData,
    input  clientReadData, clientGrant, clientDone
  );

  modport slave (
    input  clientRequest, clientWrite, clientAddress, clientWriteData,
    output clientReadData, clientGrant, clientDone
  );
endinterface

// File: rtl/sram_arbiter.sv
// Time-slices one async SRAM between a video scan-out read and NUM_CLIENTS round-robin
// clients; every 4-cycle frame is IDLE, VIDEO_READ, one client access (or NOP), COMPLETE.
module sram_arbiter #(
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CLIENTS = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [2:0]            currentState,
  input  logic [ADDR_WIDTH-1:0] videoAddress,
  output logic [DATA_WIDTH-1:0] videoData,
  output logic                  videoDataReady,
  sram_arbiter_if.slave         cif,
  output logic [ADDR_WIDTH-1:0] ramAddress,
  inout  wire  [DATA_WIDTH-1:0] ramData,
  output logic                  ramOutputEnable,
  output logic                  ramWriteEnable
);
  localparam int IDXW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_VREAD = 3'd1, S_CREAD = 3'd2,
    S_CWRITE = 3'd3, S_NOP = 3'd4, S_DONE = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [IDXW-1:0]        last_q, last_d, win_idx, cand;
  logic                   win_found;
  logic [ADDR_WIDTH-1:0]  ram_addr_q, ram_addr_d;
  logic                   oe_n_q, oe_n_d, we_n_q, we_n_d, drive_q, drive_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d, vdata_q, vdata_d, rdata_q, rdata_d;
  logic                   vrdy_q, vrdy_d;
  logic [NUM_CLIENTS-1:0] grant_q, grant_d, done_q, done_d;

  // Round-robin search: descending k so the closest client after last_q wins.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = NUM_CLIENTS; k >= 1; k--) begin
      cand = IDXW'((int'(last_q) + k) % NUM_CLIENTS);
      if (cif.clientRequest[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wdata_d = wdata_q;
    vdata_d = vdata_q;
    rdata_d = rdata_q;
    grant_d = '0;
    done_d  = '0;
    case (state_q)
      S_IDLE:  state_d = S_VREAD;
      S_VREAD: begin
        if (win_found) begin
          state_d          = cif.clientWrite[win_idx] ? S_CWRITE : S_CREAD;
          last_d           = win_idx;
          grant_d[win_idx] = 1'b1;
          wdata_d          = cif.clientWriteData[win_idx*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          state_d = S_NOP;
        end
      end
      S_CREAD, S_CWRITE, S_NOP: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    // SRAM controls are registered from the next phase so they are clean for the whole cycle.
    case (state_d)
      S_VREAD:          ram_addr_d = videoAddress;
      S_CREAD, S_CWRITE: ram_addr_d = cif.clientAddress[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
      default:          ram_addr_d = '0;
    endcase
    oe_n_d  = !(state_d == S_VREAD || state_d == S_CREAD);
    we_n_d  = (state_d != S_CWRITE);
    drive_d = (state_d == S_CWRITE);

    vrdy_d = (state_q == S_VREAD);
    if (state_q == S_VREAD) vdata_d = ramData;
    if (state_q == S_CREAD) rdata_d = ramData;
    if (state_q == S_CREAD || state_q == S_CWRITE) done_d = grant_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      last_q     <= IDXW'(NUM_CLIENTS - 1);
      ram_addr_q <= '0;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      drive_q    <= 1'b0;
      wdata_q    <= '0;
      vdata_q    <= '0;
      rdata_q    <= '0;
      vrdy_q     <= 1'b0;
      grant_q    <= '0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      ram_addr_q <= ram_addr_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      drive_q    <= drive_d;
      wdata_q    <= wdata_d;
      vdata_q    <= vdata_d;
      rdata_q    <= rdata_d;
      vrdy_q     <= vrdy_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
    end
  end

  assign ramData            = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
  assign currentState       = state_q;
  assign ramAddress         = ram_addr_q;
  assign ramOutputEnable    = oe_n_q;
  assign ramWriteEnable     = we_n_q;
  assign videoData          = vdata_q;
  assign videoDataReady     = vrdy_q;
  assign cif.clientReadData = rdata_q;
  assign cif.clientGrant    = grant_q;
  assign cif.clientDone     = done_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: the driver queues each expected access, a negedge
// monitor checks every frame phase, the SRAM pins and each clientDone against the queue.
module tb_sram_arbiter;
  localparam int AW = 17;
  localparam int DW = 8;
  localparam int N  = 2;
  localparam logic [AW-1:0] VADDR = 17'h00123;
  localparam logic [DW-1:0] VDATA = 8'h5A;

  typedef struct {
    int            client;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    currentState;
  logic [AW-1:0] videoAddress;
  logic [DW-1:0] videoData;
  logic          videoDataReady;
  logic [AW-1:0] ramAddress;
  wire  [DW-1:0] ramData;
  logic          ramOutputEnable, ramWriteEnable;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  sram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CLIENTS(N)) cif ();

  sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CLIENTS(N)) dut (
    .clock(clock), .reset(reset), .currentState(currentState),
    .videoAddress(videoAddress), .videoData(videoData), .videoDataReady(videoDataReady),
    .cif(cif), .ramAddress(ramAddress), .ramData(ramData),
    .ramOutputEnable(ramOutputEnable), .ramWriteEnable(ramWriteEnable)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Async SRAM model; preloaded on the first clock, written at the edge ending a WE-low cycle.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          loaded = 1'b0;
  assign ramData = (!ramOutputEnable) ? mem[ramAddress] : {DW{1'bz}};
  always @(posedge clock) begin
    if (!loaded) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
      mem[VADDR] <= VDATA;
      loaded     <= 1'b1;
    end else if (!ramWriteEnable) begin
      mem[ramAddress] <= ramData;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic wait_state(input logic [2:0] s);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (currentState == s) return;
    end
    chk("wait_state_timeout", 32'(currentState), 32'(s));
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (|cif.clientDone) begin
        at = cyc;
        return;
      end
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic set_client(input int c, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cif.clientWrite[c]               = wr;
    cif.clientAddress[c*AW +: AW]    = a;
    cif.clientWriteData[c*DW +: DW]  = d;
  endtask

  // Monitor: phase-by-phase checks plus scoreboard pop on clientDone.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("oe_we_both_low", 32'(ramOutputEnable | ramWriteEnable), 1);
        if (currentState != 3'd5) chk("done_outside_complete", 32'(cif.clientDone), 0);
        if (videoDataReady) begin
          chk("video_data", 32'(videoData), 32'(VDATA));
          chk("vrdy_phase", 32'(currentState inside {3'd2, 3'd3, 3'd4}), 1);
        end
        case (currentState)
          3'd1: begin
            chk("vread_addr", 32'(ramAddress), 32'(VADDR));
            chk("vread_oe", 32'(ramOutputEnable), 0);
          end
          3'd2, 3'd3: begin
            if (exp_q.size() == 0) chk("unexpected_access", 32'(currentState), 4);
            else begin
              e = exp_q[0];
              chk("grant", 32'(cif.clientGrant), 32'(1 << e.client));
              chk("access_kind", 32'(currentState), e.wr ? 3 : 2);
              chk("access_addr", 32'(ramAddress), 32'(e.addr));
              if (currentState == 3'd3) begin
                chk("write_we", 32'(ramWriteEnable), 0);
                chk("write_data", 32'(ramData), 32'(e.data));
              end else begin
                chk("read_oe", 32'(ramOutputEnable), 0);
              end
            end
          end
          3'd4: begin
            chk("nop_grant", 32'(cif.clientGrant), 0);
            chk("nop_pins", 32'({ramOutputEnable, ramWriteEnable}), 3);
          end
          3'd5: begin
            chk("complete_grant", 32'(cif.clientGrant), 0);
            if (|cif.clientDone) begin
              if (exp_q.size() == 0) chk("unexpected_done", 32'(cif.clientDone), 0);
              else begin
                e = exp_q.pop_front();
                chk("done", 32'(cif.clientDone), 32'(1 << e.client));
                if (!e.wr) chk("read_data", 32'(cif.clientReadData), 32'(e.data));
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, tprev;
    videoAddress        = VADDR;
    cif.clientRequest   = '0;
    cif.clientWrite     = '0;
    cif.clientAddress   = '0;
    cif.clientWriteData = '0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_state", 32'(currentState), 0);
    chk("rst_oe", 32'(ramOutputEnable), 1);
    chk("rst_we", 32'(ramWriteEnable), 1);
    chk("rst_addr", 32'(ramAddress), 0);
    chk("rst_vdata", 32'(videoData), 0);
    chk("rst_vrdy", 32'(videoDataReady), 0);
    chk("rst_rdata", 32'(cif.clientReadData), 0);
    chk("rst_grant", 32'(cif.clientGrant), 0);
    chk("rst_done", 32'(cif.clientDone), 0);
    reset = 1'b1;

    // Idle bus: three video-only frames
    repeat (12) @(negedge clock);

    // Client 1 write 0xC3 -> 0x1FFFF; inputs scrambled after the latch edge
    wait_state(3'd0);
    exp_q.push_back('{1, 1'b1, 17'h1FFFF, 8'hC3});
    set_client(1, 1'b1, 17'h1FFFF, 8'hC3);
    cif.clientRequest = 2'b10;
    wait_state(3'd3);
    set_client(1, 1'b1, 17'h00000, 8'hFF);
    wait_done(t);
    cif.clientRequest = 2'b00;

    // Client 0 reads it back
    wait_state(3'd0);
    exp_q.push_back('{0, 1'b0, 17'h1FFFF, 8'hC3});
    set_client(0, 1'b0, 17'h1FFFF, 8'h00);
    cif.clientRequest = 2'b01;
    wait_done(t);
    cif.clientRequest = 2'b00;

    // Both clients requesting from reset: alternate 0,1,0,1 on consecutive frames
    @(negedge clock);
    reset = 1'b0;
    set_client(0, 1'b0, 17'h1FFFF, 8'h00);
    set_client(1, 1'b0, VADDR, 8'h00);
    cif.clientRequest = 2'b11;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{0, 1'b0, 17'h1FFFF, 8'hC3});
      exp_q.push_back('{1, 1'b0, VADDR, VDATA});
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    tprev = -1;
    for (int i = 0; i < 4; i++) begin
      wait_done(t);
      if (i > 0) chk("done_gap", 32'(t - tprev), 4);
      tprev = t;
    end
    cif.clientRequest = 2'b00;

    // Client 0 drops its request right after the grant: one completion, no regrant
    wait_state(3'd0);
    exp_q.push_back('{0, 1'b0, VADDR, VDATA});
    set_client(0, 1'b0, VADDR, 8'h00);
    cif.clientRequest = 2'b01;
    wait_state(3'd2);
    cif.clientRequest = 2'b00;
    wait_done(t);
    repeat (8) @(negedge clock);
    chk("queue_after_drop", 32'(exp_q.size()), 0);

    // Reset during CLIENT_WRITE: pins released immediately, write abandoned
    wait_state(3'd0);
    exp_q.push_back('{0, 1'b1, 17'h00055, 8'h77});
    set_client(0, 1'b1, 17'h00055, 8'h77);
    cif.clientRequest = 2'b01;
    wait_state(3'd3);
    reset = 1'b0;
    #1;
    chk("midrst_we", 32'(ramWriteEnable), 1);
    chk("midrst_oe", 32'(ramOutputEnable), 1);
    chk("midrst_state", 32'(currentState), 0);
    chk("midrst_grant", 32'(cif.clientGrant), 0);
    chk("midrst_addr", 32'(ramAddress), 0);
    exp_q.delete();
    cif.clientRequest = 2'b00;
    repeat (2) @(negedge clock);
    chk("midrst_done", 32'(cif.clientDone), 0);
    set_client(0, 1'b0, 17'h00055, 8'h00);
    set_client(1, 1'b0, VADDR, 8'h00);
    exp_q.push_back('{0, 1'b0, 17'h00055, 8'h00});
    exp_q.push_back('{1, 1'b0, VADDR, VDATA});
    cif.clientRequest = 2'b11;
    @(negedge clock);
    reset = 1'b1;
    wait_done(t);
    cif.clientRequest[0] = 1'b0;
    wait_done(t);
    cif.clientRequest = 2'b00;

    repeat (8) @(negedge clock);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 17: width of the external SRAM address and of every address input.
REQ-002 Parameter DATA_WIDTH, default 8: width of the SRAM data bus and of all data ports.
REQ-003 Parameter NUM_CLIENTS, default 2, legal range 1..8: number of CPU-side memory clients.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Ports SHALL be as follows:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous active-low reset
- currentState  out  3  frame phase, debug only
- videoAddress  in  ADDR_WIDTH  scan-out address, sampled every frame
- videoData  out  DATA_WIDTH  pixel byte read in the last frame
- videoDataReady  out  1  one-cycle pulse, videoData updated
- clientRequest  in  NUM_CLIENTS  per-client request, level, held until clientDone
- clientWrite  in  NUM_CLIENTS  per-client 1=write, 0=read
- clientAddress  in  NUM_CLIENTS*ADDR_WIDTH  packed, client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- clientWriteData  in  NUM_CLIENTS*DATA_WIDTH  packed, same layout
- clientReadData  out  DATA_WIDTH  shared read-return bus
- clientGrant  out  NUM_CLIENTS  one-hot, high during the granted access phase
- clientDone  out  NUM_CLIENTS  one-hot one-cycle pulse, access complete
- ramAddress  out  ADDR_WIDTH  SRAM address, registered
- ramData  inout  DATA_WIDTH  SRAM data bus
- ramOutputEnable  out  1  active-low SRAM OE, registered
- ramWriteEnable  out  1  active-low SRAM WE, registered

Function
REQ-006 Frames SHALL run continuously with phases IDLE(0) -> VIDEO_READ(1) -> one of CLIENT_READ(2)/CLIENT_WRITE(3)/NOP(4) -> COMPLETE(5) -> IDLE; each phase lasts one cycle; a frame lasts exactly 4 cycles; codes 6-7 SHALL go to IDLE.
REQ-007 Arbitration SHALL occur in VIDEO_READ: the winner is the first asserted clientRequest scanning round-robin from (lastGranted+1) mod NUM_CLIENTS; the phase is CLIENT_WRITE if clientWrite[winner]=1, CLIENT_READ if 0, NOP if no request.
REQ-008 lastGranted SHALL update only when a grant is issued; read and write requests have equal priority.
REQ-009 Winner index, direction, address and write data SHALL be latched at the VIDEO_READ->access edge; input changes after that edge do not affect the current access.
REQ-010 ramAddress SHALL be registered from nextState: videoAddress for VIDEO_READ, the latched client address for CLIENT_READ/CLIENT_WRITE, 0 otherwise.
REQ-011 ramOutputEnable SHALL be 0 exactly during VIDEO_READ and CLIENT_READ; ramWriteEnable SHALL be 0 exactly during CLIENT_WRITE; both never low together.
REQ-012 ramData SHALL be driven with latched write data only while in CLIENT_WRITE and high-impedance in every other phase.
REQ-013 videoData SHALL capture ramData at the edge leaving VIDEO_READ; videoDataReady SHALL pulse for the following cycle (the access phase).
REQ-014 clientReadData SHALL capture ramData at the edge leaving CLIENT_READ and hold until the next CLIENT_READ.
REQ-015 clientGrant[winner] SHALL be high for the access phase only; clientDone[winner] SHALL pulse during COMPLETE; clientReadData is valid when clientDone pulses for a read.
REQ-016 A client deasserting clientRequest after being granted SHALL still complete the access; a client keeping clientRequest high after clientDone SHALL be treated as a new request in the next frame.
REQ-017 Worst-case latency from clientRequest to clientDone SHALL be 4*NUM_CLIENTS+4 cycles.

Reset
REQ-018 Asserting reset SHALL immediately force: currentState=IDLE, ramOutputEnable=1, ramWriteEnable=1, ramData released, ramAddress=0, videoData=0, videoDataReady=0, clientReadData=0, clientGrant=0, clientDone=0, lastGranted=NUM_CLIENTS-1 (so client 0 wins first).
REQ-019 Reset mid-access SHALL abandon the access without a clientDone; the first frame after release starts in IDLE.

Verification
REQ-020 Idle bus, videoAddress=0x00123, SRAM[0x00123]=0x5A -> every frame ramAddress=0x00123 with OE low in VIDEO_READ, videoData=0x5A, videoDataReady pulse, NOP phase, no grants.
REQ-021 Client 1 write 0xC3 to 0x1FFFF -> CLIENT_WRITE: WE low, ramData=0xC3, ramAddress=0x1FFFF; clientDone=2'b10 in COMPLETE; later client 0 read of 0x1FFFF returns 0xC3.
REQ-022 Both clients requesting continuously from reset -> grants alternate 0,1,0,1 on consecutive frames; no client waits more than 8 cycles.
REQ-023 Client 0 drops clientRequest the cycle after grant -> access still completes, single clientDone pulse, no second grant.
REQ-024 Reset asserted during CLIENT_WRITE -> WE and OE high and ramData Z within the same cycle, no clientDone; after release first grant goes to client 0.
REQ-025 Bus contention check throughout all scenarios: ramData never driven by the block while OE is low.
